// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH multiplier. Each RUN cycle performs one
//   ripple-carry add of the multiplicand (gated by the current multiplier LSB)
//   onto the upper partial product, then shifts {carry, sum, q} right by one.
//   After WIDTH iterations the 2*WIDTH-bit product is latched and done pulses.
//
// Ports
//   clk      in   clock, rising-edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request; sampled only in IDLE or DONE
//   a        in   WIDTH-bit multiplicand, captured on accepted start
//   b        in   WIDTH-bit multiplier, captured on accepted start
//   busy     out  high while in RUN
//   done     out  high only in DONE (one-cycle pulse)
//   product  out  2*WIDTH-bit result; holds last completed product
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;
   logic [2*WIDTH-1:0] shifted;
   logic               accept;
   logic               last_iter;

   // Ripple-carry add step: acc + (q[0] ? mcand : 0), carry-in 0.
   always_comb begin
      addend = mplier_q[0] ? mcand_q : '0;
      sum    = '0;
      carry  = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i] = acc_q[i] ^ addend[i] ^ carry;
         carry  = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
      end
   end

   // {carry, sum, q} >> 1: carry lands in the acc MSB, q LSB is consumed.
   assign shifted   = {carry, sum, mplier_q[WIDTH-1:1]};
   assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
   assign last_iter = (cnt_q == CntW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_iter) state_d = StDone;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mcand_q  <= a;
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
         end else if (state_q == StRun) begin
            acc_q    <= shifted[2*WIDTH-1:WIDTH];
            mplier_q <= shifted[WIDTH-1:0];
            cnt_q    <= cnt_q + CntW'(1);
            if (last_iter) begin
               product_q <= shifted;
            end
         end
      end
   end

   // Pure decodes of the state register: no path from start/a/b.
   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Directed self-checking bench for shift_add_multiplier (WIDTH = 4):
//   reset state, single operations, operand corners, start ignored in RUN,
//   back-to-back operation, reset abort, and a full 16x16 operand sweep.
module tb_shift_add_multiplier;

   localparam int unsigned WIDTH = 4;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   int n_checks;
   int n_pass;

   shift_add_multiplier #(
      .WIDTH(WIDTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .product(product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for done; returns edges taken, or -1 on timeout.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (done) begin
            n = i;
            break;
         end
      end
      if (n < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   // Single-pulse operation with cycle-exact busy/done checking.
   task automatic run_op(input string tag, input int av, input int bv, input int exp);
      a     = WIDTH'(av);
      b     = WIDTH'(bv);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         tick();
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
      check({tag, "_product"}, 32'(product), 32'(exp));
      tick();
      check({tag, "_done_lo"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(product), 32'(exp));
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_product", 32'(product), 32'd0);
      end

      run_op("5x3", 5, 3, 'h0F);
      tick();
      check("5x3_hold_idle", 32'(product), 32'h0F);
      run_op("15x15", 15, 15, 'hE1);
      run_op("0x15", 0, 15, 'h00);
      run_op("15x0", 15, 0, 'h00);

      // start and new operands during RUN must be ignored.
      a     = 4'd7;
      b     = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a     = 4'd2;
      b     = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      check("7x9_latency", 32'(n), 32'd2);
      check("7x9_product", 32'(product), 32'h3F);
      tick();
      check("7x9_no_queue", 32'(busy), 32'd0);
      check("7x9_done_lo", 32'(done), 32'd0);

      // Back-to-back with start held high.
      a     = 4'd3;
      b     = 4'd4;
      start = 1'b1;
      tick();
      a     = 4'd6;
      b     = 4'd7;
      for (int i = 0; i < 4; i++) tick();
      check("b2b1_done", 32'(done), 32'd1);
      check("b2b1_product", 32'(product), 32'h0C);
      tick();
      check("b2b_rerun_busy", 32'(busy), 32'd1);
      check("b2b_rerun_done", 32'(done), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("b2b2_done", 32'(done), 32'd1);
      check("b2b2_product", 32'(product), 32'h2A);
      start = 1'b0;
      tick();
      check("b2b_end_idle", 32'(busy), 32'd0);

      // Reset mid-RUN aborts; outputs clear asynchronously.
      a     = 4'd12;
      b     = 4'd11;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen = 1;
         end
         check("abort_no_done", 32'(seen), 32'd0);
      end

      // Exhaustive sweep.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            a     = WIDTH'(ai);
            b     = WIDTH'(bi);
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(n);
            check($sformatf("sweep_%0dx%0d", ai, bi), 32'(product), 32'(ai * bi));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
